irq_pend_latch: RTL and testbench

//  Upstream stage of the 8-to-3 priority encoder. Captures rising edges on N

---
 rtl/irq_pend_latch.sv | 55 +++++
 tb/tb_irq_pend_latch.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/irq_pend_latch.sv
// irq_pend_latch: edge-captured, maskable interrupt pending register feeding the priority encoder.
// Define IRQ_SYNC2_EN to pass req through a 2-flop synchronizer before edge detection.
module irq_pend_latch #(
   parameter int N = 8,
   localparam int CW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          mask_we,
   input  logic [N-1:0]  mask_wdata,
   input  logic          ack,
   input  logic [CW-1:0] ack_code,
   input  logic          ovf_clr,
   output logic [N-1:0]  pend,
   output logic          any_pend,
   output logic [N-1:0]  mask,
   output logic [N-1:0]  ovf,
   output logic          ack_err
);
   logic [N-1:0] req_s, req_q, raw_pend, edge_v, ack_vec;
`ifdef IRQ_SYNC2_EN
   logic [N-1:0] sync1, sync2;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= req;
         sync2 <= sync1;
      end
   assign req_s = sync2;
`else
   assign req_s = req;
`endif
   assign edge_v = req_s & ~req_q;
   // out-of-range codes shift the one-hot away entirely and so read as an error
   assign ack_vec = ack ? N'(1) << ack_code : '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         req_q    <= '0;
         raw_pend <= '0;
         mask     <= '1;
         ovf      <= '0;
         ack_err  <= 1'b0;
      end else begin
         req_q    <= req_s;
         raw_pend <= (raw_pend & ~ack_vec) | edge_v;
         ovf      <= (ovf & ~{N{ovf_clr}}) | (edge_v & raw_pend & ~ack_vec);
         ack_err  <= ack & ~|(ack_vec & raw_pend);
         if (mask_we) mask <= mask_wdata;
      end
   assign pend     = raw_pend & mask;
   assign any_pend = |pend;
endmodule

// File: tb/tb_irq_pend_latch.sv
// tb_irq_pend_latch: scoreboard bench with a per-line behavioural model, directed and random stimulus.
module tb_irq_pend_latch;
   logic       clk = 1'b0, rst;
   logic [7:0] req, mask_wdata, pend, mask, ovf;
   logic       mask_we, ack, ovf_clr, any_pend, ack_err;
   logic [2:0] ack_code;
   int checks = 0, errors = 0;

   typedef struct {
      logic [7:0] pend;
      logic       any;
      logic [7:0] mask;
      logic [7:0] ovf;
      logic       aerr;
   } exp_t;
   exp_t q[$];

   bit m_req[8], m_pnd[8], m_msk[8], m_ovf[8];
   bit m_aerr;

   irq_pend_latch dut (
      .clk(clk), .rst(rst), .req(req), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .ack(ack), .ack_code(ack_code), .ovf_clr(ovf_clr), .pend(pend),
      .any_pend(any_pend), .mask(mask), .ovf(ovf), .ack_err(ack_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void m_reset();
      for (int k = 0; k < 8; k++) begin
         m_req[k] = 0; m_pnd[k] = 0; m_msk[k] = 1; m_ovf[k] = 0;
      end
      m_aerr = 0;
   endfunction

   function automatic exp_t m_view();
      exp_t e;
      e.pend = '0; e.mask = '0; e.ovf = '0;
      for (int k = 0; k < 8; k++) begin
         e.pend[k] = m_pnd[k] && m_msk[k];
         e.mask[k] = m_msk[k];
         e.ovf[k]  = m_ovf[k];
      end
      e.any  = e.pend != 0;
      e.aerr = m_aerr;
      return e;
   endfunction

   // a line's event is serviced by an ack naming it; a fresh event afterwards re-arms it
   function automatic void m_step(input logic [7:0] r, input logic mwe, input logic [7:0] mwd,
                                  input logic a, input logic [2:0] code, input logic oc);
      bit was_pending;
      was_pending = m_pnd[code];
      for (int k = 0; k < 8; k++) begin
         bit rising, serviced;
         rising   = r[k] && !m_req[k];
         serviced = a && (code == k);
         if (rising && m_pnd[k] && !serviced) m_ovf[k] = 1;
         else if (oc) m_ovf[k] = 0;
         if (rising) m_pnd[k] = 1;
         else if (serviced) m_pnd[k] = 0;
         m_req[k] = r[k];
         if (mwe) m_msk[k] = mwd[k];
      end
      m_aerr = a && !was_pending;
   endfunction

   task automatic cyc(input logic [7:0] r, input logic mwe = 0, input logic [7:0] mwd = 0,
                      input logic a = 0, input logic [2:0] code = 0, input logic oc = 0);
      @(negedge clk);
      req = r; mask_we = mwe; mask_wdata = mwd; ack = a; ack_code = code; ovf_clr = oc;
      m_step(r, mwe, mwd, a, code, oc);
      q.push_back(m_view());
   endtask

   task automatic see(input string name, input logic [7:0] p, input logic [7:0] o);
      @(posedge clk);
      #2;
      chk({name, "_pend"}, pend, p);
      chk({name, "_ovf"}, ovf, o);
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("sb_pend", pend, e.pend);
         chk("sb_any", {7'b0, any_pend}, {7'b0, e.any});
         chk("sb_mask", mask, e.mask);
         chk("sb_ovf", ovf, e.ovf);
         chk("sb_ackerr", {7'b0, ack_err}, {7'b0, e.aerr});
      end
   end

   initial begin
      rst = 1; req = 0; mask_we = 0; mask_wdata = 0; ack = 0; ack_code = 0; ovf_clr = 0;
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      #1;
      chk("rst_pend", pend, 8'h00);
      chk("rst_any", {7'b0, any_pend}, 8'h00);
      chk("rst_mask", mask, 8'hFF);
      chk("rst_ovf", ovf, 8'h00);
      chk("rst_ackerr", {7'b0, ack_err}, 8'h00);
      cyc(8'h04);                         see("t2_set", 8'h04, 8'h00);
      cyc(8'h00, 0, 0, 1, 3'd2);          see("t2_ack", 8'h00, 8'h00);
      cyc(8'h22);                         see("t3_set", 8'h22, 8'h00);
      cyc(8'h00, 0, 0, 1, 3'd1);          see("t3_ack1", 8'h20, 8'h00);
      cyc(8'h00, 0, 0, 1, 3'd5);          see("t3_ack5", 8'h00, 8'h00);
      cyc(8'h00, 1, 8'hFE);
      cyc(8'h01);                         see("t4_masked", 8'h00, 8'h00);
      cyc(8'h00, 1, 8'hFF);               see("t4_unmask", 8'h01, 8'h00);
      cyc(8'h00, 0, 0, 1, 3'd0);
      cyc(8'h08);
      cyc(8'h00);
      cyc(8'h08);                         see("t5_ovf", 8'h08, 8'h08);
      cyc(8'h00, 0, 0, 0, 0, 1);          see("t5_clr", 8'h08, 8'h00);
      cyc(8'h08, 0, 0, 1, 3'd3);          see("t5_setwins", 8'h08, 8'h00);
      cyc(8'h00, 0, 0, 1, 3'd3);
      cyc(8'h00, 0, 0, 1, 3'd6);          see("t6_err", 8'h00, 8'h00);
      chk("t6_ackerr", {7'b0, ack_err}, 8'h01);
      cyc(8'h00);
      cyc(8'h08, 0, 0, 0, 0, 1);          see("t6_ovfwins_pre", 8'h08, 8'h00);
      cyc(8'h00);
      cyc(8'h08, 0, 0, 0, 0, 1);          see("t6_ovfwins", 8'h08, 8'h08);
      cyc(8'hFF);                         see("t6_all", 8'hFF, 8'h08);
      @(negedge clk);
      #2 rst = 1;
      #1;
      chk("arst_pend", pend, 8'h00);
      chk("arst_any", {7'b0, any_pend}, 8'h00);
      chk("arst_mask", mask, 8'hFF);
      chk("arst_ovf", ovf, 8'h00);
      m_reset();
      @(negedge clk);
      rst = 0;
      cyc(8'hFF);                         see("held_req", 8'hFF, 8'h00);
      for (int i = 0; i < 400; i++)
         cyc(8'($urandom & $urandom), $urandom_range(0, 9) == 0, 8'($urandom),
             $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
      cyc(8'h00);
      repeat (2) @(negedge clk);
      chk("sb_drained", 8'(q.size()), 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
